// File: rtl/tinyv_pkg.sv
// TinyV shared types: ALU opcode enum and core-wide constants.
// Imported by the decode/execute boundary and by the ALU.
package tinyv_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int REG_ZERO     = 0;

   typedef enum logic [3:0] {
      ALU_ADD     = 4'd0,
      ALU_SUB     = 4'd1,
      ALU_AND     = 4'd2,
      ALU_OR      = 4'd3,
      ALU_XOR     = 4'd4,
      ALU_SLT     = 4'd5,
      ALU_SLTU    = 4'd6,
      ALU_SLL     = 4'd7,
      ALU_SRL     = 4'd8,
      ALU_SRA     = 4'd9,
      ALU_NOP     = 4'd10,
      ALU_INVALID = 4'd11
   } alu_op_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bundle: decode payload, forwarding
// sources and the registered ALU-side outputs.
interface id_ex_stage_if
   import tinyv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int REG_AW = 5
);

   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   in_pc;
   logic [REG_AW-1:0] in_rs1_addr;
   logic [REG_AW-1:0] in_rs2_addr;
   logic              in_rs1_used;
   logic              in_rs2_used;
   logic [XLEN-1:0]   in_rs1_data;
   logic [XLEN-1:0]   in_rs2_data;
   logic [XLEN-1:0]   in_imm;
   logic              in_a_sel_pc;
   logic              in_b_sel_imm;
   alu_op_e           in_alu_sel;
   logic [REG_AW-1:0] in_rd_addr;
   logic              in_reg_write;
   logic              in_mem_read;
   logic              flush;
   logic [XLEN-1:0]   alu_result;
   logic              mem_fwd_valid;
   logic [REG_AW-1:0] mem_fwd_rd;
   logic [XLEN-1:0]   mem_fwd_data;
   logic              wb_fwd_valid;
   logic [REG_AW-1:0] wb_fwd_rd;
   logic [XLEN-1:0]   wb_fwd_data;
   logic              ex_ready;
   logic              ex_valid;
   logic [XLEN-1:0]   ex_a;
   logic [XLEN-1:0]   ex_b;
   alu_op_e           ex_alu_sel;
   logic [REG_AW-1:0] ex_rd_addr;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              ex_illegal;

   modport master (
      output in_valid, in_pc,
      output in_rs1_addr, in_rs2_addr,
      output in_rs1_used, in_rs2_used,
      output in_rs1_data, in_rs2_data,
      output in_imm, in_a_sel_pc, in_b_sel_imm,
      output in_alu_sel, in_rd_addr,
      output in_reg_write, in_mem_read,
      output flush, alu_result,
      output mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
      output wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
      output ex_ready,
      input  in_ready, ex_valid, ex_a, ex_b,
      input  ex_alu_sel, ex_rd_addr,
      input  ex_reg_write, ex_mem_read, ex_illegal
   );

   modport slave (
      input  in_valid, in_pc,
      input  in_rs1_addr, in_rs2_addr,
      input  in_rs1_used, in_rs2_used,
      input  in_rs1_data, in_rs2_data,
      input  in_imm, in_a_sel_pc, in_b_sel_imm,
      input  in_alu_sel, in_rd_addr,
      input  in_reg_write, in_mem_read,
      input  flush, alu_result,
      input  mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
      input  wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
      input  ex_ready,
      output in_ready, ex_valid, ex_a, ex_b,
      output ex_alu_sel, ex_rd_addr,
      output ex_reg_write, ex_mem_read, ex_illegal
   );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding selector: x0, then EX, MEM, WB,
// falling back to register-file data.
module fwd_mux
   import tinyv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs_addr_i,
   input  logic [XLEN-1:0]   rf_data_i,
   input  logic              ex_en_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic [XLEN-1:0]   ex_data_i,
   input  logic              mem_en_i,
   input  logic [REG_AW-1:0] mem_rd_i,
   input  logic [XLEN-1:0]   mem_data_i,
   input  logic              wb_en_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic [XLEN-1:0]   wb_data_i,
   output logic [XLEN-1:0]   data_o
);

   logic is_zero;
   logic ex_hit;
   logic mem_hit;
   logic wb_hit;

   assign is_zero = rs_addr_i == REG_AW'(REG_ZERO);
   assign ex_hit  = ex_en_i  & (ex_rd_i  == rs_addr_i);
   assign mem_hit = mem_en_i & (mem_rd_i == rs_addr_i);
   assign wb_hit  = wb_en_i  & (wb_rd_i  == rs_addr_i);

   always_comb begin
      data_o = rf_data_i;
      if (is_zero)
         data_o = '0;
      else if (ex_hit)
         data_o = ex_data_i;
      else if (mem_hit)
         data_o = mem_data_i;
      else if (wb_hit)
         data_o = wb_data_i;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwarding, operand select and
// load-use stall in front of the ALU.
module id_ex_stage
   import tinyv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int REG_AW = 5
) (
   input logic         clk,
   input logic         reset,
   id_ex_stage_if.slave bus
);

   logic              valid_q, valid_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   alu_op_e           alu_q;
   logic [REG_AW-1:0] rd_q;
   logic              rw_q, mr_q, ill_q;
   logic              ill_d;
   logic [XLEN-1:0]   rs1_fwd, rs2_fwd;
   logic              ex_fwd_en;
   logic              rs1_lu, rs2_lu;
   logic              load_use;
   logic              ready;
   logic              fire;

   // A load in EX cannot forward; it stalls decode instead.
   assign ex_fwd_en = valid_q & rw_q & ~mr_q;

   assign rs1_lu = bus.in_rs1_used & (bus.in_rs1_addr == rd_q);
   assign rs2_lu = bus.in_rs2_used & (bus.in_rs2_addr == rd_q);
   assign load_use = valid_q & mr_q
                   & (rd_q != REG_AW'(REG_ZERO))
                   & (rs1_lu | rs2_lu);

   assign ready = (~valid_q | bus.ex_ready) & ~load_use;
   assign fire  = bus.in_valid & ready;

   fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
      .rs_addr_i  (bus.in_rs1_addr),
      .rf_data_i  (bus.in_rs1_data),
      .ex_en_i    (ex_fwd_en),
      .ex_rd_i    (rd_q),
      .ex_data_i  (bus.alu_result),
      .mem_en_i   (bus.mem_fwd_valid),
      .mem_rd_i   (bus.mem_fwd_rd),
      .mem_data_i (bus.mem_fwd_data),
      .wb_en_i    (bus.wb_fwd_valid),
      .wb_rd_i    (bus.wb_fwd_rd),
      .wb_data_i  (bus.wb_fwd_data),
      .data_o     (rs1_fwd)
   );

   fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
      .rs_addr_i  (bus.in_rs2_addr),
      .rf_data_i  (bus.in_rs2_data),
      .ex_en_i    (ex_fwd_en),
      .ex_rd_i    (rd_q),
      .ex_data_i  (bus.alu_result),
      .mem_en_i   (bus.mem_fwd_valid),
      .mem_rd_i   (bus.mem_fwd_rd),
      .mem_data_i (bus.mem_fwd_data),
      .wb_en_i    (bus.wb_fwd_valid),
      .wb_rd_i    (bus.wb_fwd_rd),
      .wb_data_i  (bus.wb_fwd_data),
      .data_o     (rs2_fwd)
   );

   assign a_d   = bus.in_a_sel_pc  ? bus.in_pc  : rs1_fwd;
   assign b_d   = bus.in_b_sel_imm ? bus.in_imm : rs2_fwd;
   assign ill_d = bus.in_alu_sel == ALU_INVALID;

   always_comb begin
      valid_d = valid_q;
      if (bus.flush)
         valid_d = 1'b0;
      else if (fire)
         valid_d = 1'b1;
      else if (bus.ex_ready)
         valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         alu_q   <= ALU_NOP;
         rd_q    <= '0;
         rw_q    <= 1'b0;
         mr_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         // A flushed capture may land here; valid gating hides it.
         if (fire) begin
            a_q   <= a_d;
            b_q   <= b_d;
            alu_q <= bus.in_alu_sel;
            rd_q  <= bus.in_rd_addr;
            rw_q  <= bus.in_reg_write;
            mr_q  <= bus.in_mem_read;
            ill_q <= ill_d;
         end
      end
   end

   assign bus.in_ready     = ready;
   assign bus.ex_valid     = valid_q;
   assign bus.ex_a         = a_q;
   assign bus.ex_b         = b_q;
   assign bus.ex_alu_sel   = alu_q;
   assign bus.ex_rd_addr   = rd_q;
   assign bus.ex_reg_write = valid_q & rw_q;
   assign bus.ex_mem_read  = valid_q & mr_q;
   assign bus.ex_illegal   = valid_q & ill_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed decode traffic,
// monitor pops expected payloads as execute consumes them.
module tb_id_ex_stage;
   import tinyv_pkg::*;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      alu_op_e     alu;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t mon_e;
   exp_t mon_a;

   id_ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

   id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n,
                      input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, req);
      end
   endtask

   task automatic present(
      input logic [31:0] pc,
      input logic [4:0]  rs1, input logic [31:0] d1,
      input logic        u1,
      input logic [4:0]  rs2, input logic [31:0] d2,
      input logic        u2,
      input logic [31:0] imm,
      input logic        asel, input logic bsel,
      input alu_op_e     alu,
      input logic [4:0]  rd,
      input logic        rw, input logic mr);
      bus.in_pc        = pc;
      bus.in_rs1_addr  = rs1;
      bus.in_rs1_data  = d1;
      bus.in_rs1_used  = u1;
      bus.in_rs2_addr  = rs2;
      bus.in_rs2_data  = d2;
      bus.in_rs2_used  = u2;
      bus.in_imm       = imm;
      bus.in_a_sel_pc  = asel;
      bus.in_b_sel_imm = bsel;
      bus.in_alu_sel   = alu;
      bus.in_rd_addr   = rd;
      bus.in_reg_write = rw;
      bus.in_mem_read  = mr;
   endtask

   task automatic fwd(input logic mv, input logic [4:0] mrd,
                      input logic [31:0] md,
                      input logic wv, input logic [4:0] wrd,
                      input logic [31:0] wd,
                      input logic [31:0] alu_res);
      bus.mem_fwd_valid = mv;
      bus.mem_fwd_rd    = mrd;
      bus.mem_fwd_data  = md;
      bus.wb_fwd_valid  = wv;
      bus.wb_fwd_rd     = wrd;
      bus.wb_fwd_data   = wd;
      bus.alu_result    = alu_res;
   endtask

   // Holds in_valid until accepted, bounded to a few cycles.
   task automatic send(input exp_t e);
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 8 && !ok; i++) begin
         #1;
         if (bus.in_ready) begin
            sb.push_back(e);
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept: got no in_ready expected accept");
      end
   endtask

   always @(negedge clk) begin
      if (reset && bus.ex_valid && bus.ex_ready) begin
         checks++;
         mon_a = '{bus.ex_a, bus.ex_b, bus.ex_alu_sel,
                   bus.ex_rd_addr, bus.ex_reg_write,
                   bus.ex_mem_read, bus.ex_illegal};
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got %h expected none", mon_a);
         end else begin
            mon_e = sb.pop_front();
            if (mon_a !== mon_e) begin
               errors++;
               $display("FAIL sb_payload: got %h expected %h",
                        mon_a, mon_e);
            end
         end
      end
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.ex_ready = 1'b1;
      present(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0);
      fwd(0, 0, 0, 0, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, bus.ex_valid}, 0);
      chk("rst_alu", {28'd0, bus.ex_alu_sel}, {28'd0, ALU_NOP});
      chk("rst_a", bus.ex_a, 0);
      chk("rst_b", bus.ex_b, 0);
      chk("rst_rw", {31'd0, bus.ex_reg_write}, 0);
      chk("rst_ill", {31'd0, bus.ex_illegal}, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // plain capture
      present(0, 1, 5, 1, 2, 3, 1, 0, 0, 0, ALU_ADD, 3, 1, 0);
      send('{32'd5, 32'd3, ALU_ADD, 5'd3, 1'b1, 1'b0, 1'b0});
      chk("cap_valid", {31'd0, bus.ex_valid}, 1);

      // EX forward of x3
      present(0, 3, 0, 1, 0, 32'h12, 1, 0, 0, 0, ALU_SUB, 4, 1, 0);
      fwd(0, 0, 0, 0, 0, 0, 32'h100);
      send('{32'h100, 32'd0, ALU_SUB, 5'd4, 1'b1, 1'b0, 1'b0});

      // EX beats MEM beats WB on x4
      present(0, 4, 32'hAA, 1, 0, 0, 0, 7, 0, 1, ALU_AND, 0, 1, 0);
      fwd(1, 4, 2, 1, 4, 3, 1);
      send('{32'd1, 32'd7, ALU_AND, 5'd0, 1'b1, 1'b0, 1'b0});

      // x0 never forwards; this one is a load to x5
      present(0, 0, 32'h55, 1, 9, 32'h99, 1, 0, 0, 0,
              ALU_OR, 5, 1, 1);
      fwd(1, 0, 32'h22, 1, 0, 32'h33, 32'h77);
      send('{32'd0, 32'h99, ALU_OR, 5'd5, 1'b1, 1'b1, 1'b0});

      // load-use on rs2=x5
      present(0, 6, 32'h66, 1, 5, 32'h11, 1, 0, 0, 0,
              ALU_ADD, 8, 1, 0);
      fwd(0, 0, 0, 0, 0, 0, 32'h77);
      bus.in_valid = 1'b1;
      #1;
      chk("lu_ready", {31'd0, bus.in_ready}, 0);
      @(posedge clk);
      #1;
      chk("lu_bubble", {31'd0, bus.ex_valid}, 0);
      fwd(1, 5, 32'hCAFE, 0, 0, 0, 32'h77);
      send('{32'h66, 32'hCAFE, ALU_ADD, 5'd8, 1'b1, 1'b0, 1'b0});
      fwd(0, 0, 0, 0, 0, 0, 0);

      // backpressure: hold I5, next one waits
      present(32'h80, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 1,
              ALU_INVALID, 7, 0, 0);
      bus.ex_ready = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready", {31'd0, bus.in_ready}, 0);
         chk("bp_valid", {31'd0, bus.ex_valid}, 1);
         chk("bp_a", bus.ex_a, 32'h66);
         chk("bp_b", bus.ex_b, 32'hCAFE);
         @(posedge clk);
         #1;
      end
      bus.ex_ready = 1'b1;
      send('{32'h80, 32'hFFFF_FFFC, ALU_INVALID, 5'd7,
             1'b0, 1'b0, 1'b1});
      chk("ill_flag", {31'd0, bus.ex_illegal}, 1);

      // flush discards the instruction accepted alongside it
      present(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, ALU_ADD, 9, 1, 0);
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      chk("fl_valid", {31'd0, bus.ex_valid}, 0);
      chk("fl_rw", {31'd0, bus.ex_reg_write}, 0);
      @(posedge clk);
      #1;
      chk("sb_drain", sb.size(), 0);

      // reset while stalled
      present(0, 1, 5, 1, 2, 3, 1, 0, 0, 0, ALU_XOR, 10, 1, 0);
      send('{32'd5, 32'd3, ALU_XOR, 5'd10, 1'b1, 1'b0, 1'b0});
      bus.ex_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("ms_valid", {31'd0, bus.ex_valid}, 1);
      reset = 1'b0;
      #1;
      chk("ms_rst_valid", {31'd0, bus.ex_valid}, 0);
      chk("ms_rst_alu", {28'd0, bus.ex_alu_sel}, {28'd0, ALU_NOP});
      chk("ms_rst_a", bus.ex_a, 0);
      chk("ms_rst_rd", {27'd0, bus.ex_rd_addr}, 0);
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.ex_ready = 1'b1;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
